// File: rtl/dct_coeff_quantizer.sv
// dct_coeff_quantizer: reduces NCH signed fixed-point DCT coefficients to saturated OUT_W-bit integers.
// Latency: 2 cycles (S1 round/truncate, S2 saturate); sustains one vector per cycle.
// Backpressure: valid/ready; in_ready follows out_ready combinationally; a stalled output is held stable.
// Optional build macro QUANT_DEADZONE_EN: zero lanes whose |result| <= dz_thresh after saturation.
module dct_coeff_quantizer #(
  parameter int NCH    = 8,
  parameter int IN_W   = 19,
  parameter int FRAC_W = 6,
  parameter int OUT_W  = 13,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*IN_W-1:0]  in_data,
  input  logic                 round_mode,
  input  logic [OUT_W-2:0]     dz_thresh,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*OUT_W-1:0] out_data,
  output logic [NCH-1:0]       out_sat,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     sat_count
);

  // One bit of headroom so the rounding bias can never wrap.
  localparam int EW = IN_W + 1;
  localparam int RW = EW - FRAC_W;
  localparam int PW = $clog2(NCH + 1);
  localparam logic [EW-1:0]    C_HALF    = EW'(1) << (FRAC_W - 1);
  localparam logic [EW-1:0]    C_HALF_M1 = C_HALF - EW'(1);
  localparam logic [OUT_W-1:0] C_MAX     = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] C_MIN     = {1'b1, {(OUT_W-1){1'b0}}};

  logic                 r_s1_vld;
  logic [NCH*RW-1:0]    r_s1_r;
  logic                 r_s2_vld;
  logic [NCH*OUT_W-1:0] r_s2_dat;
  logic [NCH-1:0]       r_s2_sat;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_s1_en;
  logic                 w_s2_en;
  logic [NCH*RW-1:0]    w_s1_nxt;
  logic [NCH*OUT_W-1:0] w_s2_nxt;
  logic [NCH-1:0]       w_s2_sat_nxt;
  logic [PW-1:0]        w_pop;
  logic [CNT_W:0]       w_cnt_sum;

  // A stage may load when its successor frees up or when it is empty.
  assign w_s2_en   = out_ready | ~r_s2_vld;
  assign w_s1_en   = w_s2_en | ~r_s1_vld;
  assign in_ready  = w_s1_en;
  assign out_valid = r_s2_vld;
  assign out_data  = r_s2_dat;
  assign out_sat   = r_s2_sat;
  assign sat_count = r_cnt;

  // S1 datapath: truncate is a plain arithmetic shift; rounding adds a sign-dependent
  // bias first so halves move away from zero.
  for (genvar k = 0; k < NCH; k++) begin : g_rnd
    logic [EW-1:0] w_ext;
    logic [EW-1:0] w_bias;
    logic [EW-1:0] w_pre;
    logic          w_unused_lsb;
    assign w_ext  = {in_data[k*IN_W+IN_W-1], in_data[k*IN_W +: IN_W]};
    assign w_bias = round_mode ? (w_ext[EW-1] ? C_HALF_M1 : C_HALF) : '0;
    assign w_pre  = w_ext + w_bias;
    assign w_s1_nxt[k*RW +: RW] = w_pre[EW-1:FRAC_W];
    assign w_unused_lsb = ^w_pre[FRAC_W-1:0];
  end

  // S1 register: capture rounded lanes with each accepted vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_r   <= '0;
    end else if (w_s1_en) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_r <= w_s1_nxt;
      end
    end
  end

`ifdef QUANT_DEADZONE_EN
  logic [OUT_W-2:0] r_s1_dz;

  // S1 register: threshold travels with the vector it was sampled with
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_dz <= '0;
    end else if (w_s1_en && in_valid) begin
      r_s1_dz <= dz_thresh;
    end
  end
`else
  logic w_unused_dz;
  assign w_unused_dz = ^dz_thresh;
`endif

  // S2 datapath: clamp to OUT_W when the discarded high bits are not a pure sign extension.
  for (genvar k = 0; k < NCH; k++) begin : g_sat
    logic [RW-1:0]      w_r;
    logic [RW-OUT_W:0]  w_hi;
    logic               w_ovf;
    logic [OUT_W-1:0]   w_clamp;
    assign w_r     = r_s1_r[k*RW +: RW];
    assign w_hi    = w_r[RW-1:OUT_W-1];
    assign w_ovf   = ~((&w_hi) | ~(|w_hi));
    assign w_clamp = w_ovf ? (w_r[RW-1] ? C_MIN : C_MAX) : w_r[OUT_W-1:0];
`ifdef QUANT_DEADZONE_EN
    logic [OUT_W-1:0] w_mag;
    logic             w_dz;
    // Unsigned magnitude fits OUT_W bits even for the most negative value.
    assign w_mag = w_clamp[OUT_W-1] ? (~w_clamp + OUT_W'(1)) : w_clamp;
    assign w_dz  = (w_mag <= {1'b0, r_s1_dz});
    assign w_s2_nxt[k*OUT_W +: OUT_W] = w_dz ? '0 : w_clamp;
    assign w_s2_sat_nxt[k]            = w_ovf & ~w_dz;
`else
    assign w_s2_nxt[k*OUT_W +: OUT_W] = w_clamp;
    assign w_s2_sat_nxt[k]            = w_ovf;
`endif
  end

  // S2 register: output vector, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_dat <= '0;
      r_s2_sat <= '0;
    end else if (w_s2_en) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_dat <= w_s2_nxt;
        r_s2_sat <= w_s2_sat_nxt;
      end
    end
  end

  // Count saturated lanes on the vector currently presented
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NCH; k++) begin
      w_pop = w_pop + PW'(r_s2_sat[k]);
    end
  end

  assign w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(w_pop);

  // Saturation statistics: accumulate on output transfers, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_stats) begin
      r_cnt <= '0;
    end else if (r_s2_vld && out_ready) begin
      r_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_dct_coeff_quantizer.sv
`timescale 1ns/1ps
module tb_dct_coeff_quantizer;
  localparam int NCH = 8, IN_W = 19, FRAC_W = 6, OUT_W = 13, CNT_W = 16;
  localparam int DW = NCH * IN_W;
  localparam int QW = NCH * OUT_W;
  localparam int CNT_MAX = 2**CNT_W - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            round_mode = 1'b0;
  logic [OUT_W-2:0] dz_thresh = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [QW-1:0]   out_data;
  logic [NCH-1:0]  out_sat;
  logic            clr_stats = 1'b0;
  logic [CNT_W-1:0] sat_count;

  dct_coeff_quantizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .round_mode(round_mode), .dz_thresh(dz_thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .clr_stats(clr_stats), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    din;
    logic             rm;
    logic [OUT_W-2:0] dz;
    logic [QW-1:0]    dexp;
    logic [NCH-1:0]   sexp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [QW-1:0]  q_dat[$];
  logic [NCH-1:0] q_sat[$];
  logic [QW-1:0]  nxt_dat;
  logic [NCH-1:0] nxt_sat;
  logic [QW-1:0]  last_front;
  int   cnt_exp = 0;
  logic last_acc = 1'b0, last_ovld = 1'b0, last_irdy = 1'b0;
  logic [QW-1:0] last_odat;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: floor / round-half-away-from-zero by integer division, then clamp.
  function automatic void model(input logic [DW-1:0] din, input logic rm, input logic [OUT_W-2:0] dz,
                                output logic [QW-1:0] dq, output logic [NCH-1:0] sq);
    int x, a, q;
    logic [31:0] qb;
    dq = '0;
    sq = '0;
    for (int k = 0; k < NCH; k++) begin
      x = int'(din[k*IN_W +: IN_W]);
      if (x >= 2**(IN_W-1)) x -= 2**IN_W;
      a = (x < 0) ? -x : x;
      if (rm) q = (a + 2**(FRAC_W-1)) / 2**FRAC_W;
      else if (x < 0) q = (a + 2**FRAC_W - 1) / 2**FRAC_W;
      else q = a / 2**FRAC_W;
      if (x < 0) q = -q;
      if (q > 2**(OUT_W-1) - 1) begin q = 2**(OUT_W-1) - 1; sq[k] = 1'b1; end
      else if (q < -(2**(OUT_W-1))) begin q = -(2**(OUT_W-1)); sq[k] = 1'b1; end
`ifdef QUANT_DEADZONE_EN
      if (((q < 0) ? -q : q) <= int'(dz)) begin q = 0; sq[k] = 1'b0; end
`endif
      qb = q;
      dq[k*OUT_W +: OUT_W] = qb[OUT_W-1:0];
    end
  endfunction

  function automatic logic [DW-1:0] pk_in(input int v0, v1, v2, v3, v4, v5, v6, v7);
    int v[NCH];
    logic [31:0] b;
    logic [DW-1:0] r;
    v = '{v0, v1, v2, v3, v4, v5, v6, v7};
    r = '0;
    for (int k = 0; k < NCH; k++) begin b = v[k]; r[k*IN_W +: IN_W] = b[IN_W-1:0]; end
    return r;
  endfunction

  function automatic logic [QW-1:0] pk_out(input int v0, v1, v2, v3, v4, v5, v6, v7);
    int v[NCH];
    logic [31:0] b;
    logic [QW-1:0] r;
    v = '{v0, v1, v2, v3, v4, v5, v6, v7};
    r = '0;
    for (int k = 0; k < NCH; k++) begin b = v[k]; r[k*OUT_W +: OUT_W] = b[OUT_W-1:0]; end
    return r;
  endfunction

  function automatic int rnd_lane();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 400)) - 200;
      1: return int'($urandom_range(0, 2**IN_W - 1)) - 2**(IN_W-1);
      2: return 2**(IN_W-1) - 1 - int'($urandom_range(0, 100));
      default: return -(2**(IN_W-1)) + int'($urandom_range(0, 100));
    endcase
  endfunction

  task automatic rand_vec();
    logic [DW-1:0] d;
    logic [31:0] b;
    d = '0;
    for (int k = 0; k < NCH; k++) begin b = rnd_lane(); d[k*IN_W +: IN_W] = b[IN_W-1:0]; end
    in_data    = d;
    round_mode = 1'($urandom_range(0, 1));
    dz_thresh  = (OUT_W-1)'($urandom_range(0, 3));
    model(d, round_mode, dz_thresh, nxt_dat, nxt_sat);
  endtask

  // One clock: sample at the falling edge, score transfers, then step past the rising edge.
  task automatic tick();
    logic acc_in, acc_out;
    int   pop;
    @(negedge clk);
    acc_in    = in_valid & in_ready;
    acc_out   = out_valid & out_ready;
    last_acc  = acc_in;
    last_ovld = out_valid;
    last_irdy = in_ready;
    last_odat = out_data;
    last_front = (q_dat.size() > 0) ? q_dat[0] : '0;
    chk("sat_count", 128'(sat_count), 128'(cnt_exp));
    if (acc_out) begin
      if (q_dat.size() == 0) begin
        chk("unexpected_out_valid", 128'(out_valid), 128'(0));
      end else begin
        chk("out_data", 128'(out_data), 128'(q_dat[0]));
        chk("out_sat", 128'(out_sat), 128'(q_sat[0]));
        pop = $countones(q_sat[0]);
        cnt_exp = (cnt_exp + pop > CNT_MAX) ? CNT_MAX : cnt_exp + pop;
        void'(q_dat.pop_front());
        void'(q_sat.pop_front());
      end
    end
    if (clr_stats) cnt_exp = 0;
    if (acc_in) begin q_dat.push_back(nxt_dat); q_sat.push_back(nxt_sat); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[5];
    int sent, cyc;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_sat", 128'(out_sat), 128'(0));
    chk("rst_sat_count", 128'(sat_count), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Directed vectors with hand-derived expectations
    tbl[0] = '{pk_in(64, 96, -1, -96, 0, 32, -32, 127), 1'b0, '0,
               pk_out(1, 1, -1, -2, 0, 0, -1, 1), '0};
    tbl[1] = '{pk_in(64, 96, -1, -96, 0, 32, -32, 127), 1'b1, '0,
               pk_out(1, 2, 0, -2, 0, 1, -1, 2), '0};
    tbl[2] = '{pk_in(262143, -262144, 0, 0, 0, 0, 0, 0), 1'b1, '0,
               pk_out(4095, -4096, 0, 0, 0, 0, 0, 0), 8'h01};
    tbl[3] = '{pk_in(262143, -262144, 0, 0, 0, 0, 0, 0), 1'b0, '0,
               pk_out(4095, -4096, 0, 0, 0, 0, 0, 0), 8'h00};
`ifdef QUANT_DEADZONE_EN
    tbl[4] = '{pk_in(64, -64, 128, 0, 0, 0, 0, 0), 1'b0, 12'd1,
               pk_out(0, 0, 2, 0, 0, 0, 0, 0), 8'h00};
`else
    tbl[4] = '{pk_in(64, -64, 128, 0, 0, 0, 0, 0), 1'b0, 12'd1,
               pk_out(1, -1, 2, 0, 0, 0, 0, 0), 8'h00};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = tbl[i].din; round_mode = tbl[i].rm; dz_thresh = tbl[i].dz;
      nxt_dat = tbl[i].dexp; nxt_sat = tbl[i].sexp;
      tick();
      chk($sformatf("tbl%0d_accept", i), 128'(last_acc), 128'(1));
      in_valid = 1'b0;
      tick();
      chk($sformatf("tbl%0d_lat1_not_valid", i), 128'(last_ovld), 128'(0));
      tick();
      chk($sformatf("tbl%0d_lat2_valid", i), 128'(last_ovld), 128'(1));
    end
    chk("tbl_sat_count", 128'(sat_count), 128'(1));

    // Backpressure: five vectors, out_ready low for the first four cycles
    out_ready = 1'b0; sent = 0; cyc = 0;
    while ((sent < 5 || q_dat.size() > 0) && cyc < 40) begin
      out_ready = (cyc >= 4);
      if (sent < 5) begin
        if (!in_valid || last_acc) begin in_valid = 1'b1; rand_vec(); end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (cyc < 2) chk("bp_accept_first_two", 128'(last_acc), 128'(1));
      if (cyc == 2 || cyc == 3) begin
        chk("bp_in_ready_low", 128'(last_irdy), 128'(0));
        chk("bp_out_valid_held", 128'(last_ovld), 128'(1));
        chk("bp_out_data_held", 128'(last_odat), 128'(last_front));
      end
      if (last_acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_all_sent", 128'(sent), 128'(5));
    chk("bp_drained", 128'(q_dat.size()), 128'(0));

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      clr_stats = ($urandom_range(0, 19) == 0);
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        rand_vec();
      end
      tick();
    end
    clr_stats = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q_dat.size() > 0; i++) tick();
    chk("rand_drained", 128'(q_dat.size()), 128'(0));

    // Reset with two vectors in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = tbl[2].din; round_mode = 1'b1; dz_thresh = '0;
    nxt_dat = tbl[2].dexp; nxt_sat = tbl[2].sexp;
    tick();
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_sat_count", 128'(sat_count), 128'(0));
    chk("midrst_out_data", 128'(out_data), 128'(0));
    q_dat.delete(); q_sat.delete(); cnt_exp = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("midrst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("midrst_no_emit", 128'(last_ovld), 128'(0));

    // Clear coinciding with a saturating transfer: clear wins
    in_valid = 1'b1; in_data = tbl[2].din; round_mode = 1'b1;
    nxt_dat = tbl[2].dexp; nxt_sat = tbl[2].sexp;
    tick();
    in_valid = 1'b0;
    tick();
    clr_stats = 1'b1;
    tick();
    chk("clr_xfer_same_cycle", 128'(last_ovld), 128'(1));
    clr_stats = 1'b0;
    tick();
    chk("clr_wins", 128'(sat_count), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dct_coeff_quantizer.md
Name: dct_coeff_quantizer

Overview:
- Parametrised, pipelined fixed-point to integer converter for DCT output coefficient vectors, placed between the DCT datapath and the RLE encoder.
- Reduces NCH signed fixed-point coefficients of IN_W bits, with FRAC_W fractional bits, to OUT_W-bit signed integers.
- Supports selectable rounding, saturation, valid/ready backpressure and saturation statistics.

Parameters:
- NCH, 8, number of coefficients per vector (lanes)
- IN_W, 19, input coefficient width, two's complement
- FRAC_W, 6, fractional bits dropped; must be at least 1 and less than IN_W
- OUT_W, 13, output integer width, two's complement; must be at most IN_W-FRAC_W+1
- CNT_W, 16, saturation counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector this cycle
- in_data  in  NCH*IN_W  packed coefficients; lane k occupies bits [k*IN_W +: IN_W]
- round_mode  in  1  0 = truncate (floor), 1 = round half away from zero; sampled with each accepted vector
- dz_thresh  in  OUT_W-1  dead-zone magnitude threshold (see Optional Feature)
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts the vector
- out_data  out  NCH*OUT_W  packed integer coefficients, same lane order as in_data
- out_sat  out  NCH  per-lane flag: lane was saturated
- clr_stats  in  1  synchronous clear of sat_count
- sat_count  out  CNT_W  saturating count of saturated lanes delivered

Behaviour:
- Reset (asynchronous, rst_n low):
  - Stage valids clear; out_valid = 0.
  - out_data = 0, out_sat = 0, sat_count = 0.
  - in_ready = 1 after reset is released.
- Pipeline: two register stages S1 and S2. Latency is 2 cycles from an accepted input to out_valid when there is no backpressure. Throughput is one vector per cycle.
- Stage S1 (rounding), computed per lane with one extra bit of headroom:
  - Truncate: r = x >>> FRAC_W (arithmetic shift).
  - Round: r = (x + (x<0 ? 2^(FRAC_W-1)-1 : 2^(FRAC_W-1))) >>> FRAC_W.
- Stage S2 (saturation):
  - r is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_sat[k] = 1 when clamping changed lane k.
- Handshake:
  - s2_en = out_ready | ~s2_valid.
  - s1_en = s2_en | ~s1_valid.
  - in_ready = s1_en. This is a combinational path from out_ready; it is accepted.
  - A transfer occurs on valid & ready at a clock edge.
  - out_data and out_sat stay stable while out_valid = 1 and out_ready = 0.
  - Stage registers load only when their enable is high; there are no bubbles while out_ready is held high.
- sat_count:
  - On each output transfer, sat_count adds popcount(out_sat) and saturates at 2^CNT_W-1.
  - clr_stats sets sat_count to 0. If a clear and a transfer occur in the same cycle, the clear wins.
- round_mode and dz_thresh are captured into S1 together with the data. Changing them mid-stream affects only vectors accepted after the change.
- Asserting reset mid-operation discards all in-flight vectors. No partial vector is emitted afterwards.
- in_valid is ignored when in_ready = 0. The upstream block must hold its data until accepted.

Optional Feature:
- Macro: QUANT_DEADZONE_EN.
- With the macro defined:
  - In S2, after saturation, any lane with |result| <= dz_thresh is forced to 0.
  - out_sat for a lane zeroed this way is 0.
  - dz_thresh = 0 zeroes only lanes that are already 0.
- Without the macro: dz_thresh is ignored (the port stays present) and outputs are the saturated results unchanged.

Test Plan:
All cases use default parameters.
- Truncation, round_mode=0, lanes {64, 96, -1, -96, 0, 32, -32, 127} -> out_data {1, 1, -1, -2, 0, 0, -1, 1}, out_sat=0, 2-cycle latency.
- Rounding, same lanes with round_mode=1 -> {1, 2, 0, -2, 0, 1, -1, 2}.
- Saturation, round_mode=1, lane0=262143, lane1=-262144 -> lane0=4095 with out_sat[0]=1, lane1=-4096 with out_sat[1]=0; sat_count increments by 1. The same input with round_mode=0 gives 4095 and no saturation.
- Backpressure, 5 vectors streamed while out_ready is held low for 4 cycles:
  - in_ready drops after 2 vectors are accepted.
  - out_data is held stable while stalled.
  - All 5 vectors are delivered in order with no loss or duplication.
- Reset and stats: assert rst_n low with 2 vectors in flight -> out_valid=0 immediately and sat_count=0. After release, clr_stats pulsed in the same cycle as a saturating transfer -> sat_count=0.
- With QUANT_DEADZONE_EN, dz_thresh=1, lanes {64, -64, 128, 0, ...} -> {0, 0, 2, 0, ...}. Without the macro -> {1, -1, 2, 0, ...}.
